// File: rtl/store_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer_pkg : shared sizes for the posted-write store buffer |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package store_buffer_pkg;

  localparam int SB_DEPTH   = 4;
  localparam int SB_ADDR_W  = 32;
  localparam int SB_DATA_W  = 32;
  localparam int SB_MASK_W  = 4;
  localparam int SB_WADDR_W = SB_ADDR_W - 2;

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer_fwd : per-byte youngest-match load forwarding mux    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH   = SB_DEPTH,
  parameter int WADDR_W = SB_WADDR_W,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [PTR_W-1:0]           head,
  input  logic [DEPTH*WADDR_W-1:0]   addrs,
  input  logic [DEPTH*SB_DATA_W-1:0] datas,
  input  logic [DEPTH*SB_MASK_W-1:0] masks,
  input  logic [WADDR_W-1:0]         lookup_addr,
  input  logic [SB_DATA_W-1:0]       mem_rdata,
  output logic [SB_DATA_W-1:0]       rdata
);

  logic [WADDR_W-1:0]   w_addr [DEPTH];
  logic [SB_DATA_W-1:0] w_data [DEPTH];
  logic [SB_MASK_W-1:0] w_mask [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign w_addr[i] = addrs[i*WADDR_W +: WADDR_W];
    assign w_data[i] = datas[i*SB_DATA_W +: SB_DATA_W];
    assign w_mask[i] = masks[i*SB_MASK_W +: SB_MASK_W];
  end

  // Walk oldest to youngest so a later match overrides an earlier one per lane.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_idx = '0;
    rdata = mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head + PTR_W'(k);
      for (int b = 0; b < SB_MASK_W; b++) begin
        if (valid[w_idx] && (w_addr[w_idx] == lookup_addr) && w_mask[w_idx][b]) begin
          rdata[8*b +: 8] = w_data[w_idx][8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer : posted-write FIFO between core data port and memory|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        core_addr,
  input  logic [DATA_W-1:0]        core_wdata,
  input  logic [SB_MASK_W-1:0]     core_wmask,
  input  logic                     core_wen,
  input  logic                     core_ren,
  output logic [DATA_W-1:0]        core_rdata,
  output logic                     core_stall,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [SB_MASK_W-1:0]     mem_wmask,
  output logic                     mem_wen,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WADDR_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [WADDR_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0]    r_data [DEPTH];
  logic [SB_MASK_W-1:0] r_mask [DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_W-1:0]     r_count;

  logic w_empty, w_drain, w_push;
  logic [DEPTH-1:0]           w_valid;
  logic [DEPTH*WADDR_W-1:0]   w_addrs;
  logic [DEPTH*SB_DATA_W-1:0] w_datas;
  logic [DEPTH*SB_MASK_W-1:0] w_masks;

  assign w_empty    = (r_count == '0);
  assign w_drain    = !w_empty && !core_ren && mem_ready;
  assign core_stall = (core_wen && (r_count == c_full) && !w_drain) || (flush && !w_empty);
  assign w_push     = core_wen && !core_stall;
  assign empty      = w_empty;
  assign count      = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset: validity is derived from head and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= core_addr[ADDR_W-1:2];
      r_data[r_tail] <= core_wdata;
      r_mask[r_tail] <= core_wmask;
    end
  end

  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_wen   = 1'b0;
    if (!core_ren && !w_empty) begin
      mem_addr  = {r_addr[r_head], 2'b00};
      mem_wdata = r_data[r_head];
      mem_wmask = r_mask[r_head];
      mem_wen   = mem_ready;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign w_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
    assign w_addrs[i*WADDR_W +: WADDR_W]     = r_addr[i];
    assign w_datas[i*SB_DATA_W +: SB_DATA_W] = r_data[i];
    assign w_masks[i*SB_MASK_W +: SB_MASK_W] = r_mask[i];
  end

  store_buffer_fwd #(
    .DEPTH   (DEPTH),
    .WADDR_W (WADDR_W),
    .PTR_W   (PTR_W)
  ) u_fwd (
    .valid       (w_valid),
    .head        (r_head),
    .addrs       (w_addrs),
    .datas       (w_datas),
    .masks       (w_masks),
    .lookup_addr (core_addr[ADDR_W-1:2]),
    .mem_rdata   (mem_rdata),
    .rdata       (core_rdata)
  );

  a_no_rw_collision: assert property (@(posedge clk) disable iff (rst) !(core_wen && core_ren));

endmodule
`default_nettype wire
